// File: rtl/fea_packer.sv
// fea_packer: collects FEA_NUM streamed HOG features into one packed block
// vector and presents it to the SVM through a single-entry valid/ready output
// register. Feature 0 sits at the LSB. A block that completes while the output
// register is stalled is dropped and flagged by the sticky overflow bit.
module fea_packer #(
    parameter int FEA_W   = 12,
    parameter int FEA_NUM = 36,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FEA_W-1:0]         fea,
    input  logic                     i_valid,
    input  logic                     i_clr,
    output logic [FEA_NUM*FEA_W-1:0] blk_data,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic                     overflow,
    output logic [CNT_W-1:0]         blk_cnt
);

    localparam int BLK_W = FEA_NUM * FEA_W;
    localparam int IDX_W = (FEA_NUM > 1) ? $clog2(FEA_NUM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FEA_NUM - 1);

    // Drop one feature into its slot of a partially assembled block.
    function automatic logic [BLK_W-1:0] insert_fea(
        input logic [BLK_W-1:0] blk,
        input logic [IDX_W-1:0] idx,
        input logic [FEA_W-1:0] f
    );
        logic [BLK_W-1:0] res;
        res = blk;
        for (int k = 0; k < FEA_NUM; k++) begin
            if (idx == IDX_W'(k)) begin
                res[k*FEA_W +: FEA_W] = f;
            end
        end
        return res;
    endfunction

    // Control state (reset) and datapath state (assembly register unreset).
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             o_valid_q,  o_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] blk_cnt_q,  blk_cnt_d;
    logic [BLK_W-1:0] asm_q,      asm_d;
    logic [BLK_W-1:0] out_q,      out_d;

    // Per-cycle events.
    logic wr_en;      // a feature is accepted into the assembly register
    logic last_fea;   // the accepted feature completes the block
    logic handshake;  // downstream takes the current output this edge
    logic load_out;   // completed block moves into the output register
    logic drop_blk;   // completed block has nowhere to go

    // Decode this cycle's write, completion, handshake and drop events.
    always_comb begin
        wr_en     = i_valid & ~i_clr;
        last_fea  = wr_en & (idx_q == IDX_LAST);
        handshake = o_valid_q & o_ready;
        load_out  = last_fea & (~o_valid_q | handshake);
        drop_blk  = last_fea & o_valid_q & ~o_ready;
    end

    // Feature index: restart on clear, advance per accepted feature, wrap on the last one.
    always_comb begin
        idx_d = idx_q;
        if (i_clr) begin
            idx_d = '0;
        end else if (wr_en) begin
            idx_d = last_fea ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Assembly and output data: the output captures the block including the
    // feature written this very cycle, so the copy is taken from asm_d.
    always_comb begin
        asm_d = asm_q;
        out_d = out_q;
        if (wr_en) begin
            asm_d = insert_fea(asm_q, idx_q, fea);
        end
        if (load_out) begin
            out_d = asm_d;
        end
    end

    // Output valid, sticky overflow and accepted-block counter.
    always_comb begin
        o_valid_d  = o_valid_q;
        overflow_d = overflow_q;
        blk_cnt_d  = blk_cnt_q;
        if (load_out) begin
            o_valid_d = 1'b1;
        end else if (handshake) begin
            o_valid_d = 1'b0;
        end
        if (drop_blk) begin
            overflow_d = 1'b1;
        end
        if (handshake) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
    end

    // Control registers and the visible output block, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            o_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            blk_cnt_q  <= '0;
            out_q      <= '0;
        end else begin
            idx_q      <= idx_d;
            o_valid_q  <= o_valid_d;
            overflow_q <= overflow_d;
            blk_cnt_q  <= blk_cnt_d;
            out_q      <= out_d;
        end
    end

    // Assembly register: unwritten slots are don't-care, so no reset is needed.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign blk_data = out_q;
    assign o_valid  = o_valid_q;
    assign overflow = overflow_q;
    assign blk_cnt  = blk_cnt_q;

endmodule

// File: tb/tb_fea_packer.sv
// Bench for fea_packer: table of single-block transfers plus hand-written
// stall/overflow, coincident load+handshake, clear and async reset sequences.
// Expected blocks are queued when driven and checked at each handshake.
module tb_fea_packer;

    localparam int FEA_W   = 12;
    localparam int FEA_NUM = 36;
    localparam int CNT_W   = 16;
    localparam int BLK_W   = FEA_NUM * FEA_W;

    logic             clk;
    logic             rst;
    logic [FEA_W-1:0] fea;
    logic             i_valid;
    logic             i_clr;
    logic [BLK_W-1:0] blk_data;
    logic             o_valid;
    logic             o_ready;
    logic             overflow;
    logic [CNT_W-1:0] blk_cnt;

    fea_packer #(
        .FEA_W   (FEA_W),
        .FEA_NUM (FEA_NUM),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fea      (fea),
        .i_valid  (i_valid),
        .i_clr    (i_clr),
        .blk_data (blk_data),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .overflow (overflow),
        .blk_cnt  (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [BLK_W-1:0] exp_q[$];

    typedef struct {
        int         base;
        int         gap_max;
        logic [11:0] exp_lsb;
        logic [11:0] exp_msb;
    } vec_t;
    vec_t tbl[5];

    function automatic logic [BLK_W-1:0] make_blk(input int base);
        logic [BLK_W-1:0] b;
        b = '0;
        for (int k = 0; k < FEA_NUM; k++) begin
            b[k*FEA_W +: FEA_W] = FEA_W'(base + k);
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_feature(input int v);
        i_valid = 1'b1;
        fea     = FEA_W'(v);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic send_block(input int base, input int gap_max);
        for (int k = 0; k < FEA_NUM; k++) begin
            send_feature(base + k);
            if (k < FEA_NUM - 1) begin
                repeat ($urandom_range(0, gap_max)) tick();
            end
        end
    endtask

    // Scoreboard: every handshake must match the oldest queued block.
    always @(negedge clk) begin
        if (rst && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_handshake: got handshake with blk_data[11:0]=%0d expected none", blk_data[11:0]);
            end else begin
                chk_blk("handshake_data", blk_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{base: 1,    gap_max: 0, exp_lsb: 12'd1,    exp_msb: 12'd36};
        tbl[1] = '{base: 1,    gap_max: 5, exp_lsb: 12'd1,    exp_msb: 12'd36};
        tbl[2] = '{base: 200,  gap_max: 2, exp_lsb: 12'd200,  exp_msb: 12'd235};
        tbl[3] = '{base: 4060, gap_max: 0, exp_lsb: 12'd4060, exp_msb: 12'd4095};
        tbl[4] = '{base: 0,    gap_max: 1, exp_lsb: 12'd0,    exp_msb: 12'd35};

        rst = 1'b0; i_valid = 1'b0; i_clr = 1'b0; fea = '0; o_ready = 1'b1;
        repeat (3) tick();
        check("rst_o_valid", o_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_blk_cnt", blk_cnt, 0);
        chk_blk("rst_blk_data", blk_data, '0);
        rst = 1'b1;
        tick();

        // Single blocks with o_ready held high, contiguous and gapped.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(make_blk(tbl[i].base));
            send_block(tbl[i].base, tbl[i].gap_max);
            check("tbl_o_valid_set", o_valid, 1);
            check("tbl_lsb", blk_data[11:0], tbl[i].exp_lsb);
            check("tbl_msb", blk_data[431:420], tbl[i].exp_msb);
            tick();
            check("tbl_o_valid_clr", o_valid, 0);
            check("tbl_blk_cnt", blk_cnt, i + 1);
        end

        // Stall: A held, B dropped with overflow, then A drains.
        o_ready = 1'b0;
        exp_q.push_back(make_blk(300));
        send_block(300, 1);
        check("stall_a_valid", o_valid, 1);
        check("stall_a_no_ovf", overflow, 0);
        send_block(600, 2);
        check("stall_ovf_set", overflow, 1);
        check("stall_still_valid", o_valid, 1);
        chk_blk("stall_hold_a", blk_data, make_blk(300));
        o_ready = 1'b1;
        tick();
        check("stall_drain_valid", o_valid, 0);
        check("stall_drain_cnt", blk_cnt, 6);
        check("stall_ovf_sticky", overflow, 1);

        // Reset between edges clears the sticky flag and counter.
        #2 rst = 1'b0;
        #1;
        check("rst2_overflow", overflow, 0);
        check("rst2_blk_cnt", blk_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // B's last feature coincides with A's handshake.
        o_ready = 1'b0;
        exp_q.push_back(make_blk(10));
        send_block(10, 0);
        for (int k = 0; k < FEA_NUM - 1; k++) send_feature(20 + k);
        o_ready = 1'b1;
        exp_q.push_back(make_blk(20));
        send_feature(20 + FEA_NUM - 1);
        check("coinc_valid", o_valid, 1);
        check("coinc_lsb", blk_data[11:0], 12'd20);
        check("coinc_ovf", overflow, 0);
        check("coinc_cnt_a", blk_cnt, 1);
        tick();
        check("coinc_valid_clr", o_valid, 0);
        check("coinc_cnt", blk_cnt, 2);

        // Clear with a simultaneous valid drops the partial block and that feature.
        for (int k = 0; k < 20; k++) send_feature(50 + k);
        i_clr = 1'b1;
        send_feature(999);
        i_clr = 1'b0;
        exp_q.push_back(make_blk(100));
        send_block(100, 0);
        check("clr_valid", o_valid, 1);
        check("clr_lsb", blk_data[11:0], 12'd100);
        tick();
        check("clr_valid_clr", o_valid, 0);
        check("clr_cnt", blk_cnt, 3);

        // Async reset mid-block while a block is held and overflow is set.
        o_ready = 1'b0;
        send_block(700, 0);
        send_block(800, 0);
        check("arst_pre_ovf", overflow, 1);
        check("arst_pre_valid", o_valid, 1);
        for (int k = 0; k < 10; k++) send_feature(900 + k);
        #2 rst = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_overflow", overflow, 0);
        check("arst_blk_cnt", blk_cnt, 0);
        chk_blk("arst_blk_data", blk_data, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        o_ready = 1'b1;
        exp_q.push_back(make_blk(1000));
        send_block(1000, 3);
        check("arst_blk_valid", o_valid, 1);
        check("arst_blk_lsb", blk_data[11:0], 12'd1000);
        check("arst_blk_msb", blk_data[431:420], 12'd1035);
        tick();
        check("arst_blk_valid_clr", o_valid, 0);
        check("arst_blk_cnt_after", blk_cnt, 1);

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
